pixel_fetch_ctrl: RTL and testbench

Controller that sequences the image ROM (single read port, combinational `spo`) for the edge-detection pipeline. On `start` it walks the ROM in raster order and streams each pixel downstream on a valid/ready interface, tagged with frame and line markers. It also arbitrates the ROM's one read port between that stream engine and a random-access debug read port.

---
 rtl/pixel_fetch_if.sv | 30 +++
 rtl/pixel_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_pixel_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_if.sv
// Bus bundle for pixel_fetch_ctrl: ROM read port, pixel stream and debug read port.
// Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
// once m_valid is high, m_data and the flags hold until that transfer.
interface pixel_fetch_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_spo;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output mem_a, m_valid, m_data, m_sof, m_eol, m_eof, dbg_ack, dbg_data,
    input  mem_spo, m_ready, dbg_req, dbg_addr
  );

  modport slave (
    input  mem_a, m_valid, m_data, m_sof, m_eol, m_eof, dbg_ack, dbg_data,
    output mem_spo, m_ready, dbg_req, dbg_addr
  );
endinterface

// File: rtl/pixel_fetch_ctrl.sv
// Raster-order image ROM fetcher with a shared random-access debug read port.
// The ROM has one combinational read port; each cycle at most one of the
// stream engine or the debug port owns it, round-robin under contention.
module pixel_fetch_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg,
  pixel_fetch_if.master bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last_dbg;   // 1: debug won the last grant
  logic              sreq;
  logic              dreq;
  logic              grant_s;
  logic              grant_d;
  logic              last_idx;
  logic              last_col;
  logic              hs;

  assign state_dbg = state;
  assign last_idx  = (index == ADDR_W'(NPIX - 1));
  assign last_col  = (col == COL_W'(IMG_W - 1));
  assign hs        = bus.m_valid && bus.m_ready;

  // Requests and one-hot grant; contention goes to whoever did not win last.
  always_comb begin
    sreq    = (state == RUN) && (!bus.m_valid || bus.m_ready);
    dreq    = bus.dbg_req && !bus.dbg_ack;
    grant_s = sreq && (!dreq || last_dbg);
    grant_d = dreq && (!sreq || !last_dbg);
  end

  // ROM address follows the granted requester, stream index otherwise.
  assign bus.mem_a = grant_d ? bus.dbg_addr : index;

  // Frame FSM, stream output register, debug read register and arbiter memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      index        <= '0;
      col          <= '0;
      row          <= '0;
      last_dbg     <= 1'b1;
      bus.m_valid  <= 1'b0;
      bus.m_data   <= '0;
      bus.m_sof    <= 1'b0;
      bus.m_eol    <= 1'b0;
      bus.m_eof    <= 1'b0;
      bus.dbg_ack  <= 1'b0;
      bus.dbg_data <= '0;
    end else begin
      if (grant_d) begin
        bus.dbg_data <= bus.mem_spo;
        bus.dbg_ack  <= 1'b1;
      end else begin
        bus.dbg_ack  <= 1'b0;
      end

      if (grant_s) begin
        last_dbg <= 1'b0;
      end else if (grant_d) begin
        last_dbg <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            index <= '0;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (grant_s) begin
            bus.m_data  <= bus.mem_spo;
            bus.m_valid <= 1'b1;
            bus.m_sof   <= (index == '0);
            bus.m_eol   <= last_col;
            bus.m_eof   <= last_idx;
            index       <= index + ADDR_W'(1);
            if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (last_idx) begin
              state <= DRAIN;
            end
          end else if (hs) begin
            bus.m_valid <= 1'b0;
            bus.m_sof   <= 1'b0;
            bus.m_eol   <= 1'b0;
            bus.m_eof   <= 1'b0;
          end
        end
        DRAIN: begin
          if (hs) begin
            bus.m_valid <= 1'b0;
            bus.m_sof   <= 1'b0;
            bus.m_eol   <= 1'b0;
            bus.m_eof   <= 1'b0;
            state       <= DONE;
            done        <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Directed bench for pixel_fetch_ctrl with a ROM model mem[i]=i*0x11 and a
// scoreboard of expected stream beats.
module tb_pixel_fetch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  pixel_fetch_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  pixel_fetch_ctrl #(.ADDR_W(4), .DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model
  logic [7:0] rom [0:15];
  initial for (int i = 0; i < 16; i++) rom[i] = 8'(i * 17);
  assign bus.mem_spo = rom[bus.mem_a];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: {sof, eol, eof, data}
  logic [10:0] exp_q [$];
  int          cyc = 0;
  int          hs_cnt = 0;
  int          last_hs_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_frame();
    for (int i = 0; i < 16; i++)
      exp_q.push_back({(i == 0), (i % 4 == 3), (i == 15), 8'(i * 17)});
  endtask

  // monitor: handshakes, stall hold, done pulses
  always @(negedge clk) begin
    logic [10:0] beat;
    logic [10:0] e;
    if (rst_n) begin
      beat = {bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data};
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_hold", 32'(beat), 32'(prev_beat));
      end
      if (bus.m_valid && bus.m_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(beat), 32'h7ff);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'(beat), 32'(e));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_beat  = beat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one frame from just after the start edge until busy drops.
  task automatic run_frame(input bit toggle, input int start_at, input int dbg_at,
                           output int ncyc);
    int dlat;
    dlat = 0;
    ncyc = 0;
    while (busy && ncyc < 80) begin
      if (toggle) bus.m_ready = ~bus.m_ready;
      if (ncyc == start_at) start = 1'b1;
      if (ncyc == dbg_at) begin
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 4'h5;
      end
      tick();
      start = 1'b0;
      ncyc++;
      if (bus.dbg_req) begin
        dlat++;
        if (bus.dbg_ack) begin
          chk("dbg_run_lat_le2", 32'(dlat <= 2), 32'd1);
          chk("dbg_run_data", 32'(bus.dbg_data), 32'h55);
          bus.dbg_req = 1'b0;
        end else if (dlat >= 4) begin
          chk("dbg_run_timeout", 32'(dlat), 32'd2);
          bus.dbg_req = 1'b0;
        end
      end
    end
    chk("busy_bound", 32'(ncyc < 80), 32'd1);
  endtask

  task automatic check_frame_end(input string tag, input int hs_base, input int done_base);
    chk({tag, "_hs"}, 32'(hs_cnt - hs_base), 32'd16);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt - done_base), 32'd1);
    chk({tag, "_done_time"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
  endtask

  initial begin
    int n;
    int hb;
    int db;
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.m_ready  = 1'b1;
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_flags", 32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_dbg", 32'({bus.dbg_ack, bus.dbg_data}), 32'd0);
    chk("rst_mem_a", 32'(bus.mem_a), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // frame 1: full throughput
    hb = hs_cnt; db = done_cnt;
    push_frame();
    pulse_start();
    chk("f1_busy_after_e0", 32'(busy), 32'd1);
    chk("f1_valid_after_e0", 32'(bus.m_valid), 32'd0);
    run_frame(1'b0, -1, -1, n);
    chk("f1_busy_cycles", 32'(n), 32'd18);
    check_frame_end("f1", hb, db);

    // frame 2: m_ready toggles 1,0,1,0...
    hb = hs_cnt; db = done_cnt;
    push_frame();
    pulse_start();
    run_frame(1'b1, -1, -1, n);
    check_frame_end("f2", hb, db);
    bus.m_ready = 1'b1;
    tick();

    // frame 3: debug read during RUN costs exactly one bubble
    hb = hs_cnt; db = done_cnt;
    push_frame();
    pulse_start();
    run_frame(1'b0, -1, 4, n);
    chk("f3_busy_cycles", 32'(n), 32'd19);
    check_frame_end("f3", hb, db);

    // debug read in IDLE
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 4'hA;
    tick();
    chk("dbg_idle_ack", 32'(bus.dbg_ack), 32'd1);
    chk("dbg_idle_data", 32'(bus.dbg_data), 32'hAA);
    bus.dbg_req = 1'b0;
    tick();
    chk("dbg_idle_ack_drop", 32'(bus.dbg_ack), 32'd0);

    // frame 4: start pulsed during RUN is ignored
    hb = hs_cnt; db = done_cnt;
    push_frame();
    pulse_start();
    run_frame(1'b0, 5, -1, n);
    chk("f4_busy_cycles", 32'(n), 32'd18);
    check_frame_end("f4", hb, db);
    tick();
    chk("f4_idle_after", 32'(busy), 32'd0);

    // frame 5: aborted by reset after beat 7
    hb = hs_cnt; db = done_cnt;
    push_frame();
    pulse_start();
    n = 0;
    while ((hs_cnt - hb) < 8 && n < 40) begin
      tick();
      n++;
    end
    chk("abort_reach_beat7", 32'(hs_cnt - hb), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bus.m_valid), 32'd0);
    chk("abort_out", 32'({bus.m_sof, bus.m_eol, bus.m_eof, bus.m_data}), 32'd0);
    chk("abort_mem_a", 32'(bus.mem_a), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_no_done", 32'(done_cnt - db), 32'd0);

    // frame 6: restart after abort
    hb = hs_cnt; db = done_cnt;
    push_frame();
    pulse_start();
    run_frame(1'b0, -1, -1, n);
    chk("f6_busy_cycles", 32'(n), 32'd18);
    check_frame_end("f6", hb, db);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
